// File: rtl/router_dst_port.sv
// rtl/router_dst_port.sv - destination-side output FIFO with lfd tagging and optional stall flush
// Optional feature macro: ROUTER_DST_TIMEOUT_EN (stall-timeout soft reset).
module router_dst_port #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              lfd,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              sop_out,
    output logic              vld_out,
    output logic              ovf,
    output logic              soft_rst
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              sop_q, sop_d;
    logic              ovf_q, ovf_d;
    logic              soft_rst_q, soft_rst_d;
    logic              wr_acc, rd_acc, flush;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign vld_out  = (count_q != '0);
    assign dout     = dout_q;
    assign sop_out  = sop_q;
    assign ovf      = ovf_q;
    assign soft_rst = soft_rst_q;

`ifdef ROUTER_DST_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stalled;

    always_comb begin
        stalled     = vld_out && !rd_en;
        flush       = stalled && (stall_cnt_q == STALL_LAST);
        stall_cnt_d = '0;
        if (stalled && !flush) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 1);
    assign flush          = 1'b0;
`endif

    // A flush edge never has rd_en set, so only the write side needs masking.
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && vld_out;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        sop_d      = sop_q;
        ovf_d      = ovf_q;
        soft_rst_d = flush;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            dout_d  = '0;
            sop_d   = 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf_d = 1'b1;
            end
            if (wr_acc) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (rd_acc) begin
                rptr_d          = rptr_q + AW'(1);
                {sop_d, dout_d} = mem_q[rptr_q];
            end
            count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= {lfd, din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            sop_q      <= 1'b0;
            ovf_q      <= 1'b0;
            soft_rst_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            sop_q      <= sop_d;
            ovf_q      <= ovf_d;
            soft_rst_q <= soft_rst_d;
        end
    end

endmodule

// File: tb/tb_router_dst_port.sv
// tb/tb_router_dst_port.sv - scoreboard bench for router_dst_port against a queue-based model
// Honours ROUTER_DST_TIMEOUT_EN when the design is built with it.
module tb_router_dst_port;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;
`ifdef ROUTER_DST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              lfd = 1'b0;
    logic              full;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              sop_out;
    logic              vld_out;
    logic              ovf;
    logic              soft_rst;

    router_dst_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .lfd(lfd), .full(full),
        .rd_en(rd_en), .dout(dout), .sop_out(sop_out), .vld_out(vld_out),
        .ovf(ovf), .soft_rst(soft_rst)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: FIFO contents, sticky flags and last presented word.
    logic [DATA_W:0] mq[$];
    logic [DATA_W:0] sb[$];
    logic [DATA_W:0] last_m = '0;
    bit              ovf_m = 1'b0;
    bit              soft_m = 1'b0;
    int              stall_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_status();
        chk("vld_out", 32'(vld_out), 32'(mq.size() != 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("ovf", 32'(ovf), 32'(ovf_m));
        chk("soft_rst", 32'(soft_rst), 32'(soft_m));
        chk("dout_hold", 32'({sop_out, dout}), 32'(last_m));
    endtask

    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic l, input logic r);
        int n;
        bit fl;
        @(negedge clk);
        check_status();
        wr_en = w; din = d; lfd = l; rd_en = r;
        n  = mq.size();
        fl = TO_EN && (n != 0) && !r && (stall_m == TIMEOUT - 1);
        if (fl) begin
            mq.delete();
            stall_m = 0;
            soft_m  = 1'b1;
            last_m  = '0;
        end else begin
            soft_m = 1'b0;
            if (n != 0 && !r) stall_m++;
            else stall_m = 0;
            if (w && n == DEPTH) ovf_m = 1'b1;
            if (r && n != 0) begin
                last_m = mq.pop_front();
                sb.push_back(last_m);
            end
            if (w && n < DEPTH) mq.push_back({l, d});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_sop", 32'(sop_out), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_vld", 32'(vld_out), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_soft", 32'(soft_rst), 0);
        mq.delete(); sb.delete();
        ovf_m = 1'b0; soft_m = 1'b0; stall_m = 0; last_m = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: after every edge with an accepted read, dout must match the oldest expected word.
    initial begin
        bit fire;
        logic [DATA_W:0] exp;
        forever begin
            @(posedge clk);
            fire = rd_en && vld_out && !rst;
            @(negedge clk);
            if (fire) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_read", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_read", 32'({sop_out, dout}), 32'(exp));
                end
            end
        end
    end

    initial begin
        int pr, pw;
        repeat (2) @(negedge clk);
        chk("init_vld", 32'(vld_out), 0);
        chk("init_dout", 32'(dout), 0);
        chk("init_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // Basic three-byte packet
        step(1, 8'hA5, 1, 0); step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
        repeat (3) step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);

        // Reset mid-traffic
        step(1, 8'h11, 1, 0); step(1, 8'h22, 0, 0);
        do_reset();
        step(0, 0, 0, 0);

        // Fill past full, then drain
        for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(8'h30 + i), (i == 0), 0);
        repeat (DEPTH + 3) step(0, 0, 0, 1);

        // Simultaneous read/write when full, then when empty
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h50 + i), (i == 0), 0);
        step(1, 8'hEE, 0, 1);
        repeat (DEPTH) step(0, 0, 0, 1);
        step(1, 8'h77, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Long stall (flushes only with the timeout feature), then just-below-limit stall
        do_reset();
        step(1, 8'h3C, 1, 0);
        repeat (TIMEOUT + 5) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 8'h4D, 1, 0);
        repeat (TIMEOUT - 1) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        repeat (100) step(0, 0, 0, 0);

        // Randomised traffic with phase-varying read/write bias
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                pw = $urandom_range(10, 90);
                pr = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 90);
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            step(($urandom_range(0, 99) < pw), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < pr));
        end
        repeat (3) step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
